// File: rtl/seg_display_pkg.sv
// -----------------------------------------------------------------------------
// seg_display_pkg
// Shared definitions for the seven-segment display controller:
//   - conversion FSM state type
//   - active-low glyph table (seg[0]=a ... seg[6]=g)
//   - per-nibble add-3 helper used by the double-dabble step
// -----------------------------------------------------------------------------
package seg_display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // Active-low glyphs 0-9, A, b, C, d, E, F (bit order gfedcba)
  localparam logic [6:0] GLYPH_HEX [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  // Double-dabble correction: a nibble of 5 or more would exceed 9 after
  // doubling, so pre-add 3 to make it carry into the next decade.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_bcd_dd_step.sv
// -----------------------------------------------------------------------------
// bcd_dd_step
// One combinational double-dabble iteration on a DIGITS-nibble BCD vector:
// every nibble >= 5 gets +3, then the vector shifts left by one with bit_i
// entering the LSB.
//   bcd_i   : BCD vector before the iteration
//   bit_i   : next binary bit (MSB first)
//   bcd_o   : BCD vector after the iteration
//   carry_o : bit shifted out of the top nibble (decimal overflow)
// -----------------------------------------------------------------------------
module bcd_dd_step #(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] bcd_i,
  input  logic                bit_i,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                carry_o
);
  import seg_display_pkg::*;

  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = add3(bcd_i[4*i +: 4]);
    end
  end

  assign bcd_o   = {adj[4*DIGITS-2:0], bit_i};
  assign carry_o = adj[4*DIGITS-1];

endmodule

// File: rtl/seg_display_ctrl.sv
// -----------------------------------------------------------------------------
// seg_display_ctrl
// N-digit multiplexed seven-segment controller. Converts a binary value to
// decimal with a sequential double-dabble engine (or passes it through as
// hex), applies leading-zero blanking, an optional minus sign and an 'E'
// overflow pattern, then scans the digits on active-low anodes.
//
//   state  | meaning
//   IDLE   | display stable, watching for a new value/mode or a forced refresh
//   LOAD   | capture value/mode, take magnitude of negative signed input
//   SHIFT  | one double-dabble iteration per cycle, WIDTH cycles
//   COMMIT | build glyphs and blank mask, load display registers
//
// Ports:
//   clk      : system clock
//   reset    : synchronous active-low reset
//   value    : binary value to show
//   hex_mode : 1 = hex digits, 0 = decimal
//   blank_lz : 1 = blank leading zeros
//   seg      : active-low segments, seg[0]=a ... seg[6]=g
//   an       : active-low one-hot anodes
//   busy     : conversion in progress
// -----------------------------------------------------------------------------
module seg_display_ctrl #(
  parameter int DIGITS      = 4,
  parameter int WIDTH       = 16,
  parameter int REFRESH_DIV = 100000,
  parameter int SIGNED_EN   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  value,
  input  logic              hex_mode,
  input  logic              blank_lz,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy
);
  import seg_display_pkg::*;

  localparam int BCD_W  = 4 * DIGITS;
  localparam int ITER_W = $clog2(WIDTH + 1);
  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = $clog2(DIGITS);

  state_t                   state_q, state_d;
  logic [WIDTH-1:0]         raw_q, raw_d;
  logic [WIDTH-1:0]         bin_q, bin_d;
  logic                     mode_q, mode_d;
  logic                     neg_q, neg_d;
  logic                     ovf_q, ovf_d;
  logic [BCD_W-1:0]         bcd_q, bcd_d;
  logic [ITER_W-1:0]        iter_q, iter_d;
  logic [WIDTH-1:0]         last_value_q, last_value_d;
  logic                     last_mode_q, last_mode_d;
  logic                     force_conv_q, force_conv_d;
  logic [DIGITS-1:0][6:0]   glyph_q, glyph_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [6:0]               seg_q, seg_d;
  logic [DIGITS-1:0]        an_q, an_d;

  logic [BCD_W-1:0]         step_bcd;
  logic                     step_carry;

  logic [BCD_W+WIDTH-1:0]   hex_wide;
  logic [BCD_W-1:0]         digits_c;
  logic                     ovf_c;
  int                       msd_c;
  logic [DIGITS-1:0][6:0]   glyph_new;

  bcd_dd_step #(
    .DIGITS (DIGITS)
  ) u_step (
    .bcd_i   (bcd_q),
    .bit_i   (bin_q[WIDTH-1]),
    .bcd_o   (step_bcd),
    .carry_o (step_carry)
  );

  // Glyphs for the value being committed. Only meaningful in COMMIT, but
  // also used to bypass the display registers so the new glyphs reach seg
  // on the commit edge itself.
  always_comb begin
    hex_wide = {{BCD_W{1'b0}}, raw_q};
    if (mode_q) begin
      digits_c = hex_wide[BCD_W-1:0];
      ovf_c    = |(hex_wide >> BCD_W);
    end else begin
      digits_c = bcd_q;
      ovf_c    = ovf_q;
    end

    msd_c = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits_c[4*i +: 4] != 4'd0) msd_c = i;
    end

    // The minus sign needs a free digit above the most-significant one.
    if (neg_q && msd_c == DIGITS - 1) ovf_c = 1'b1;

    glyph_new = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf_c) begin
        glyph_new[i] = GLYPH_E;
      end else if (neg_q && i == msd_c + 1) begin
        glyph_new[i] = GLYPH_MINUS;
      end else if ((blank_lz || neg_q) && i > msd_c) begin
        glyph_new[i] = GLYPH_BLANK;
      end else begin
        glyph_new[i] = GLYPH_HEX[digits_c[4*i +: 4]];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    raw_d        = raw_q;
    bin_d        = bin_q;
    mode_d       = mode_q;
    neg_d        = neg_q;
    ovf_d        = ovf_q;
    bcd_d        = bcd_q;
    iter_d       = iter_q;
    last_value_d = last_value_q;
    last_mode_d  = last_mode_q;
    force_conv_d = force_conv_q;
    glyph_d      = glyph_q;

    case (state_q)
      IDLE: begin
        if (force_conv_q || value != last_value_q || hex_mode != last_mode_q) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        raw_d  = value;
        mode_d = hex_mode;
        bin_d  = value;
        neg_d  = 1'b0;
        if (!hex_mode && SIGNED_EN != 0 && value[WIDTH-1]) begin
          bin_d = -value;
          neg_d = 1'b1;
        end
        bcd_d   = '0;
        ovf_d   = 1'b0;
        iter_d  = ITER_W'(WIDTH);
        state_d = hex_mode ? COMMIT : SHIFT;
      end
      SHIFT: begin
        bcd_d  = step_bcd;
        bin_d  = bin_q << 1;
        if (step_carry) ovf_d = 1'b1;
        iter_d = iter_q - ITER_W'(1);
        if (iter_q == ITER_W'(1)) state_d = COMMIT;
      end
      COMMIT: begin
        glyph_d      = glyph_new;
        last_value_d = raw_q;
        last_mode_d  = mode_q;
        force_conv_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit scan. seg and an are both registered from the same index so the
  // lit anode and its pattern always change on the same edge.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = (state_q == COMMIT) ? glyph_new[idx_q] : glyph_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      raw_q        <= '0;
      bin_q        <= '0;
      mode_q       <= 1'b0;
      neg_q        <= 1'b0;
      ovf_q        <= 1'b0;
      bcd_q        <= '0;
      iter_q       <= '0;
      last_value_q <= '0;
      last_mode_q  <= 1'b0;
      force_conv_q <= 1'b1;
      glyph_q      <= {DIGITS{GLYPH_BLANK}};
      cnt_q        <= '0;
      idx_q        <= '0;
      seg_q        <= GLYPH_BLANK;
      an_q         <= '1;
    end else begin
      state_q      <= state_d;
      raw_q        <= raw_d;
      bin_q        <= bin_d;
      mode_q       <= mode_d;
      neg_q        <= neg_d;
      ovf_q        <= ovf_d;
      bcd_q        <= bcd_d;
      iter_q       <= iter_d;
      last_value_q <= last_value_d;
      last_mode_q  <= last_mode_d;
      force_conv_q <= force_conv_d;
      glyph_q      <= glyph_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = (state_q != IDLE);

endmodule
